md_hazard_ctrl: RTL and testbench

- Sequencer for the EX-stage multiply/divide unit.
- Issues the one-cycle start pulse for mult/multu/div/divu.
- Mirrors the unit's latency counter in its own registers, so the decode-stage stall comes straight from controller state.
- Sits between the D/E pipeline registers and the MD unit. Freezes F/D and injects an EX bubble while an MD-class instruction in D would collide with an in-flight operation.

---
 rtl/md_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_md_hazard_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: sequencer between the D/E pipeline registers and the EX-stage
// multiply/divide unit. Issues the start pulse, keeps a copy of the unit's
// latency countdown, and stalls decode while an MD op would collide.
// Optional build macro: MD_STALL_PERF_EN adds saturating stall/issue counters.
module md_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_md_op,
    input  logic             d_md_use,
    output logic             md_start,
    output logic [3:0]       md_op,
    output logic             stall_d,
    output logic             md_busy,
    output logic             issue_err
`ifdef MD_STALL_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      md_ops_issued
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               start_cls, md_cls;

    // Opcode classification, start pulse and the decode stall.
    always_comb begin
        start_cls = (e_md_op >= 4'd1) && (e_md_op <= 4'd4);
        md_cls    = (e_md_op >= 4'd1) && (e_md_op <= 4'd8);
        md_start  = e_valid && start_cls && (state_q == IDLE);
        md_busy   = (state_q == BUSY);
        stall_d   = d_md_use && (md_start || md_busy);
        // Bubbles must not look like mthi/mtlo to the unit.
        md_op     = e_valid ? e_md_op : 4'd0;
        issue_err = err_q;
    end

    // Next-state: load latency on start, count down while busy, latch errors.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // Any valid MD op reaching EX while busy means D was not held off.
        err_d   = err_q | ((state_q == BUSY) && e_valid && md_cls);
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = BUSY;
                    cnt_d   = (e_md_op <= 4'd2) ? CNT_W'(MULT_CYCLES)
                                                : CNT_W'(DIV_CYCLES);
                end
            end
            BUSY: begin
                // Exit on the last busy cycle; <=1 also guards against a
                // zero count ever getting stuck or wrapping.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

`ifdef MD_STALL_PERF_EN
    // Saturating counters for stalled cycles and issued operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            md_ops_issued <= '0;
        end else begin
            if (stall_d && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (md_start && (md_ops_issued != 32'hFFFF_FFFF))
                md_ops_issued <= md_ops_issued + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// tb_md_hazard_ctrl: directed test-plan sequences followed by random traffic,
// every cycle checked against a remaining-latency reference model.
module tb_md_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic        d_md_use;
    logic        md_start;
    logic [3:0]  md_op;
    logic        stall_d;
    logic        md_busy;
    logic        issue_err;
`ifdef MD_STALL_PERF_EN
    logic [31:0] stall_cycles, md_ops_issued;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: cycles of unit latency still outstanding.
    int  m_rem   = 0;
    bit  m_err   = 1'b0;
    bit  m_known = 1'b0;
    int  m_stalls = 0;
    int  m_issued = 0;

    // Observed run lengths for scenario-level checks.
    int  busy_len, stall_len, start_cnt;

    md_hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_md_op   (e_md_op),
        .d_md_use  (d_md_use),
        .md_start  (md_start),
        .md_op     (md_op),
        .stall_d   (stall_d),
        .md_busy   (md_busy),
        .issue_err (issue_err)
`ifdef MD_STALL_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .md_ops_issued (md_ops_issued)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int latency(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return 5;   // mult, multu
            4'd3, 4'd4: return 10;  // div, divu
            default:    return 0;
        endcase
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, then advance the model.
    task automatic cyc(input bit r, input bit ev, input logic [3:0] op, input bit du);
        bit exp_busy, exp_start, exp_stall;
        @(negedge clk);
        reset = r; e_valid = ev; e_md_op = op; d_md_use = du;
        #1;
        exp_busy  = (m_rem > 0);
        exp_start = ev && (latency(op) > 0) && !exp_busy;
        exp_stall = du && (exp_start || exp_busy);
        if (m_known) begin
            chk("md_start",  {31'd0, md_start},  {31'd0, exp_start});
            chk("md_busy",   {31'd0, md_busy},   {31'd0, exp_busy});
            chk("stall_d",   {31'd0, stall_d},   {31'd0, exp_stall});
            chk("issue_err", {31'd0, issue_err}, {31'd0, m_err});
            chk("md_op",     {28'd0, md_op},     {28'd0, (ev ? op : 4'd0)});
`ifdef MD_STALL_PERF_EN
            chk("stall_cycles",  stall_cycles,  m_stalls);
            chk("md_ops_issued", md_ops_issued, m_issued);
`endif
        end
        if (md_busy === 1'b1)  busy_len++;
        if (stall_d === 1'b1)  stall_len++;
        if (md_start === 1'b1) start_cnt++;
        @(posedge clk);
        if (r) begin
            m_rem = 0; m_err = 1'b0; m_known = 1'b1;
            m_stalls = 0; m_issued = 0;
        end else begin
            if (exp_busy && ev && op >= 4'd1 && op <= 4'd8) m_err = 1'b1;
            if (exp_stall) m_stalls++;
            if (exp_start) begin
                m_rem = latency(op);
                m_issued++;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
    endtask

    task automatic clr_stats();
        busy_len = 0; stall_len = 0; start_cnt = 0;
    endtask

    initial begin
        reset = 1'b1; e_valid = 1'b0; e_md_op = 4'd0; d_md_use = 1'b0;
        clr_stats();

        // Reset held two cycles, then idle.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Mult with decode using MD the whole time.
        clr_stats();
        cyc(0, 1, 4'd1, 1);
        for (int i = 0; i < 7; i++) cyc(0, 0, 4'd0, 1);
        chk("mult_busy_len",  busy_len,  5);
        chk("mult_stall_len", stall_len, 6);
        chk("mult_starts",    start_cnt, 1);

        // Divu with no MD use in decode: busy 10, never stall.
        clr_stats();
        cyc(0, 1, 4'd4, 0);
        for (int i = 0; i < 11; i++) cyc(0, 0, 4'd0, 0);
        chk("divu_busy_len",  busy_len,  10);
        chk("divu_stall_len", stall_len, 0);

        // Pass-through ops while idle.
        for (int op = 5; op <= 8; op++) cyc(0, 1, 4'(op), 1);

        // Div then Mult exactly on the first idle cycle.
        clr_stats();
        cyc(0, 1, 4'd3, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 4'd0, 0);
        cyc(0, 1, 4'd1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 4'd0, 0);
        chk("b2b_starts",   start_cnt, 2);
        chk("b2b_busy_len", busy_len,  15);
        chk("b2b_err",      {31'd0, issue_err}, 32'd0);

        // Illegal multu while busy: dropped, sticky error, first op unaffected.
        clr_stats();
        cyc(0, 1, 4'd1, 0);
        cyc(0, 0, 4'd0, 0);
        cyc(0, 0, 4'd0, 0);
        cyc(0, 1, 4'd2, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 4'd0, 0);
        chk("illegal_starts",   start_cnt, 1);
        chk("illegal_busy_len", busy_len,  5);
        chk("illegal_err",      {31'd0, issue_err}, 32'd1);

        // Reset in the middle of a div, then a fresh mult.
        clr_stats();
        cyc(0, 1, 4'd3, 1);
        cyc(0, 0, 4'd0, 1);
        cyc(1, 0, 4'd0, 1);
        cyc(0, 0, 4'd0, 1);
        cyc(0, 1, 4'd1, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 4'd0, 1);
        chk("rst_mid_busy_len", busy_len, 2 + 5);
        chk("rst_mid_err",      {31'd0, issue_err}, 32'd0);

        // Random traffic with occasional resets to clear the sticky error.
        for (int i = 0; i < 1500; i++) begin
            bit         r, ev, du;
            logic [3:0] op;
            r  = ($urandom_range(0, 59) == 0);
            ev = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8));
            du = $urandom_range(0, 1) != 0;
            cyc(r, ev, op, du);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
